// File: rtl/tc_io_pad_ctrl.sv
// Pad configuration sequencer: applies direction/drive/pull changes to a bank of IO cells,
// isolating a pad for a settle window before any oe or pull change, and synchronises pad input data.
module tc_io_pad_ctrl #(
  parameter int            NumPads      = 8,
  parameter int            SettleCycles = 4,
  parameter logic [3:0]    DefaultDrive = 4'h4,
  localparam int           PadIdxW      = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [PadIdxW-1:0]     cfg_pad_i,
  input  logic                   cfg_oe_i,
  input  logic [3:0]             cfg_drive_i,
  input  logic [1:0]             cfg_pull_i,
  output logic                   err_o,
  output logic                   busy_o,
  input  logic [NumPads-1:0]     core_data_i,
  output logic [NumPads-1:0]     core_data_o,
  output logic [NumPads-1:0]     io_data_o,
  input  logic [NumPads-1:0]     io_data_i,
  output logic [NumPads-1:0]     io_direction_oe_no,
  output logic [4*NumPads-1:0]   io_driving_strength_o,
  output logic [NumPads-1:0]     io_pullup_en_o,
  output logic [NumPads-1:0]     io_pulldown_en_o
);

  localparam int                CntW      = $clog2(SettleCycles + 1);
  localparam logic [PadIdxW:0]  NumPadsW  = (PadIdxW + 1)'(NumPads);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t               state, state_next;
  logic [CntW-1:0]      cnt;
  logic [NumPads-1:0]   oe_no_q, pu_q, pd_q;
  logic [3:0]           drv_q [NumPads];
  logic [NumPads-1:0]   sync1_q, sync2_q;
  logic                 err_q;

  logic [PadIdxW-1:0]   lat_pad;
  logic                 lat_oe;
  logic [3:0]           lat_drive;
  logic [1:0]           lat_pull;

  logic                 handshake, bad, in_range;
  logic [PadIdxW-1:0]   pad_sel;
  logic                 cur_oe;
  logic [1:0]           cur_pull;
  logic [3:0]           cur_drive;
  logic                 do_seq, do_drive, do_apply;

  assign handshake = cfg_valid_i && (state == IDLE) && !rst_i;
  assign in_range  = ({1'b0, cfg_pad_i} < NumPadsW);
  assign bad       = (cfg_pull_i == 2'b11) || !in_range;
  // Out-of-range indices must not read past the register arrays.
  assign pad_sel   = in_range ? cfg_pad_i : '0;
  assign cur_oe    = ~oe_no_q[pad_sel];
  assign cur_pull  = {pd_q[pad_sel], pu_q[pad_sel]};
  assign cur_drive = drv_q[pad_sel];

  always_comb begin
    state_next = state;
    do_seq     = 1'b0;
    do_drive   = 1'b0;
    do_apply   = 1'b0;
    case (state)
      IDLE: begin
        if (handshake && !bad) begin
          if ((cfg_oe_i != cur_oe) || (cfg_pull_i != cur_pull)) begin
            do_seq     = 1'b1;
            state_next = SETTLE;
          end else if (cfg_drive_i != cur_drive) begin
            do_drive = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          do_apply   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oe_no_q   <= '1;
      pu_q      <= '0;
      pd_q      <= '0;
      for (int i = 0; i < NumPads; i++) drv_q[i] <= DefaultDrive;
      sync1_q   <= '0;
      sync2_q   <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      lat_pad   <= '0;
      lat_oe    <= 1'b0;
      lat_drive <= '0;
      lat_pull  <= '0;
    end else begin
      sync1_q <= io_data_i;
      sync2_q <= sync1_q;
      err_q   <= handshake && bad;
      if (do_drive) drv_q[cfg_pad_i] <= cfg_drive_i;
      // Break-before-make: isolate the pad now, drive strength is left as-is.
      if (do_seq) begin
        oe_no_q[cfg_pad_i] <= 1'b1;
        pu_q[cfg_pad_i]    <= 1'b0;
        pd_q[cfg_pad_i]    <= 1'b0;
        lat_pad            <= cfg_pad_i;
        lat_oe             <= cfg_oe_i;
        lat_drive          <= cfg_drive_i;
        lat_pull           <= cfg_pull_i;
        cnt                <= CntW'(SettleCycles - 1);
      end
      if (state == SETTLE) begin
        if (do_apply) begin
          oe_no_q[lat_pad] <= ~lat_oe;
          drv_q[lat_pad]   <= lat_drive;
          pu_q[lat_pad]    <= lat_pull[0];
          pd_q[lat_pad]    <= lat_pull[1];
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NumPads; i++) begin : g_drive
    assign io_driving_strength_o[4*i +: 4] = drv_q[i];
  end

  assign cfg_ready_o        = (state == IDLE) || rst_i;
  assign busy_o             = (state == SETTLE);
  assign err_o              = err_q;
  assign core_data_o        = sync2_q;
  assign io_data_o          = core_data_i;
  assign io_direction_oe_no = oe_no_q;
  assign io_pullup_en_o     = pu_q;
  assign io_pulldown_en_o   = pd_q;

endmodule
